// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, FSM states, ALU ops, address map and ALU helpers for the multicycle MIPS core
package mips_pkg;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] PORT_OUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] PORT_IN_ADDR = 32'h1001_0028;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} stateT;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI} aluOpT;
  function automatic aluOpT decodeAluOp(input logic [5:0] opcode, input logic [5:0] funct);
    if (opcode == OP_RTYPE)
      case (funct)
        FN_SUB: return ALU_SUB;
        FN_AND: return ALU_AND;
        FN_OR: return ALU_OR;
        FN_NOR: return ALU_NOR;
        FN_SLT: return ALU_SLT;
        FN_SLL: return ALU_SLL;
        FN_SRL: return ALU_SRL;
        default: return ALU_ADD;
      endcase
    case (opcode)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI: return ALU_OR;
      OP_LUI: return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction
  // shifts and lui operate on the second operand (rt / immediate)
  function automatic logic [31:0] aluCompute(input aluOpT op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    case (op)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR: return x | y;
      ALU_NOR: return ~(x | y);
      ALU_SLT: return {31'b0, $signed(x) < $signed(y)};
      ALU_SLL: return y << sh;
      ALU_SRL: return y >> sh;
      ALU_LUI: return {y[15:0], 16'h0};
      default: return x + y;
    endcase
  endfunction
endpackage

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: state register and opcode/funct decode into datapath enables and mux selects
// Ports: clk, reset (async active-low), opcode/funct from IR, equal (A==B);
//        state, aluOp, pcSrc (0 ALU, 1 ALUOut, 2 jump, 3 A) and per-state write enables, InstrRetired, Trap.
// Build option: MIPS_TRAP_EN makes illegal instructions enter a terminal TRAP state instead of retiring as NOPs.
module mips_control_fsm import mips_pkg::*; (
  input logic clk,
  input logic reset,
  input logic [5:0] opcode,
  input logic [5:0] funct,
  input logic equal,
  output stateT state,
  output aluOpT aluOp,
  output logic [1:0] pcSrc,
  output logic pcWrite, irWrite, abWrite, aluOutWrite, aluSrcImm, zeroExt,
  output logic memWrite, mdrWrite, regWrite, regDstRd, link, memToReg,
  output logic InstrRetired,
  output logic Trap
);
`ifdef MIPS_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  stateT next;
  logic isR, isJr, isLw, isSw, isJal, isJump, isBranch, ctrlFlow, legal, taken;
  assign isR = opcode == OP_RTYPE;
  assign isJr = isR && funct == FN_JR;
  assign isLw = opcode == OP_LW;
  assign isSw = opcode == OP_SW;
  assign isJal = opcode == OP_JAL;
  assign isJump = isJal || opcode == OP_J;
  assign isBranch = opcode inside {OP_BEQ, OP_BNE};
  assign ctrlFlow = isBranch || isJump || isJr;
  assign taken = opcode == OP_BEQ ? equal : opcode == OP_BNE && !equal;
  assign legal = isR ? funct inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT}
                     : opcode inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= next;
  always_comb
    case (state)
      FETCH: next = DECODE;
      DECODE: next = legal ? EXECUTE : TRAP_EN ? TRAP : FETCH;
      EXECUTE: next = ctrlFlow ? FETCH : (isLw || isSw) ? MEMORY : WRITEBACK;
      MEMORY: next = isLw ? WRITEBACK : FETCH;
      TRAP: next = TRAP;
      default: next = FETCH;
    endcase
  // FETCH and DECODE borrow the ALU for PC+4 and the branch target
  always_comb begin
    irWrite = state == FETCH;
    abWrite = state == DECODE;
    pcWrite = irWrite || (state == EXECUTE && (taken || isJump || isJr));
    pcSrc = irWrite ? 2'd0 : isJr ? 2'd3 : isJump ? 2'd2 : 2'd1;
    aluOutWrite = abWrite || (state == EXECUTE && !ctrlFlow);
    aluOp = state == EXECUTE ? decodeAluOp(opcode, funct) : ALU_ADD;
    aluSrcImm = !isR;
    zeroExt = opcode inside {OP_ANDI, OP_ORI, OP_LUI};
    memWrite = state == MEMORY && isSw;
    mdrWrite = state == MEMORY && isLw;
    regWrite = state == WRITEBACK || (state == EXECUTE && isJal);
    regDstRd = isR;
    link = isJal;
    memToReg = isLw;
    InstrRetired = state == WRITEBACK || (state == EXECUTE && ctrlFlow) || memWrite || (abWrite && !legal && !TRAP_EN);
    Trap = TRAP_EN && state == TRAP;
  end
endmodule

// File: rtl/mips_multicycle_processor.sv
// mips_multicycle_processor: multicycle MIPS core with program ROM, data RAM and memory-mapped ports
// Ports: clk, reset (async active-low), PortIn (read at 0x1001_0028), ALUResultOut (ALUOut register),
//        PortOut (written at 0x1001_0024), InstrRetired (pulse in final state), Trap (sticky, MIPS_TRAP_EN only).
// PROGRAM holds the ROM image, word i in bits [32*i+31:32*i].
module mips_multicycle_processor import mips_pkg::*; #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_DEPTH = 64,
  parameter int PORT_IN_WIDTH = 8,
  parameter int PORT_OUT_WIDTH = 32,
  parameter logic [MEMORY_DEPTH*32-1:0] PROGRAM = '0
) (
  input logic clk,
  input logic reset,
  input logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0] ALUResultOut,
  output logic [PORT_OUT_WIDTH-1:0] PortOut,
  output logic InstrRetired,
  output logic Trap
);
  localparam int ROM_AW = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1;
  localparam int DATA_AW = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;
  localparam logic [31:0] SP_INIT = DATA_BASE + 32'(4 * DATA_DEPTH) - 32'd4;
  logic [31:0] pc, ir, a, b, mdr, aluOut, pcNext, romWord, romIndex, dataIndex, readData;
  logic [31:0] sextImm, immExt, srcA, srcB, aluResult, wData;
  logic [31:0] regFile [32];
  logic [31:0] rom [MEMORY_DEPTH];
  logic [31:0] ram [DATA_DEPTH];
  logic [4:0] rs, rt, rd, wAddr;
  logic [1:0] pcSrc;
  logic pcWrite, irWrite, abWrite, aluOutWrite, aluSrcImm, zeroExt, memWrite, mdrWrite;
  logic regWrite, regDstRd, link, memToReg, inRam, isPortIn, isPortOut;
  stateT state;
  aluOpT aluOp;
  mips_control_fsm u_fsm (
    .clk(clk), .reset(reset), .opcode(ir[31:26]), .funct(ir[5:0]), .equal(a == b),
    .state(state), .aluOp(aluOp), .pcSrc(pcSrc), .pcWrite(pcWrite), .irWrite(irWrite),
    .abWrite(abWrite), .aluOutWrite(aluOutWrite), .aluSrcImm(aluSrcImm), .zeroExt(zeroExt),
    .memWrite(memWrite), .mdrWrite(mdrWrite), .regWrite(regWrite), .regDstRd(regDstRd),
    .link(link), .memToReg(memToReg), .InstrRetired(InstrRetired), .Trap(Trap)
  );
  for (genvar g = 0; g < MEMORY_DEPTH; g++) begin : g_rom
    assign rom[g] = PROGRAM[g*32 +: 32];
  end
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign sextImm = {{16{ir[15]}}, ir[15:0]};
  assign immExt = zeroExt ? {16'h0, ir[15:0]} : sextImm;
  assign romIndex = (pc - TEXT_BASE) >> 2;
  assign romWord = romIndex < 32'(MEMORY_DEPTH) ? rom[romIndex[ROM_AW-1:0]] : '0;
  assign srcA = (state == FETCH || state == DECODE) ? pc : a;
  assign srcB = state == FETCH ? 32'd4 : state == DECODE ? {sextImm[29:0], 2'b00} : aluSrcImm ? immExt : b;
  assign aluResult = aluCompute(aluOp, srcA, srcB, ir[10:6]);
  assign pcNext = pcSrc == 2'd0 ? aluResult : pcSrc == 2'd1 ? aluOut : pcSrc == 2'd2 ? {pc[31:28], ir[25:0], 2'b00} : a;
  // the low two address bits are ignored everywhere, so port matches mask them too
  assign dataIndex = (aluOut - DATA_BASE) >> 2;
  assign inRam = dataIndex < 32'(DATA_DEPTH);
  assign isPortIn = {aluOut[31:2], 2'b00} == PORT_IN_ADDR;
  assign isPortOut = {aluOut[31:2], 2'b00} == PORT_OUT_ADDR;
  assign readData = isPortIn ? 32'(PortIn) : inRam ? ram[dataIndex[DATA_AW-1:0]] : '0;
  assign wAddr = link ? 5'd31 : regDstRd ? rd : rt;
  assign wData = link ? pc : memToReg ? mdr : aluOut;
  assign ALUResultOut = aluOut;
  always_ff @(posedge clk)
    if (memWrite && inRam && !isPortOut) ram[dataIndex[DATA_AW-1:0]] <= b;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= TEXT_BASE;
      ir <= '0;
      a <= '0;
      b <= '0;
      mdr <= '0;
      aluOut <= '0;
      PortOut <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= (i == 29) ? SP_INIT : '0;
    end else begin
      if (pcWrite) pc <= pcNext;
      if (irWrite) ir <= romWord;
      if (abWrite) begin
        a <= regFile[rs];
        b <= regFile[rt];
      end
      if (aluOutWrite) aluOut <= aluResult;
      if (mdrWrite) mdr <= readData;
      if (memWrite && isPortOut) PortOut <= PORT_OUT_WIDTH'(b);
      if (regWrite && wAddr != 5'd0) regFile[wAddr] <= wData;
    end
endmodule

// File: tb/tb_mips_multicycle_processor.sv
// tb_mips_multicycle_processor: directed checks of the multicycle MIPS core, one DUT instance per program
module tb_mips_multicycle_processor;
`ifdef MIPS_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif
  localparam logic [63:0] P1 = {32'h2109FFF9, 32'h20080005};
  localparam logic [511:0] P2 = 512'({32'hAC280000, 32'h200800A5, 32'h34210024, 32'h3C011001});
  localparam logic [511:0] P3 = 512'({32'h8D6D0040, 32'hAD6A0040, 32'h200D0007, 32'h8D6C0004,
                                       32'hAD6A0004, 32'h8D6A0028, 32'h3C0B1001});
  localparam logic [511:0] P4 = 512'(32'h1000FFFF);
  localparam logic [511:0] P5 = 512'(32'h1400FFFF);
  localparam logic [511:0] P6 = 512'({32'h03E00008, 96'h0, 32'h0C100004});
  localparam logic [511:0] P7 = 512'(32'hFC000000);
  logic clk = 1'b0;
  logic [6:0] rst = '0;
  logic [6:0] ret, trp;
  logic [7:0] pin = '0;
  logic [31:0] aluR [7];
  logic [31:0] pOut [7];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mips_multicycle_processor #(.MEMORY_DEPTH(2), .DATA_DEPTH(16), .PROGRAM(P1)) u1 (.clk(clk), .reset(rst[0]),
    .PortIn(pin), .ALUResultOut(aluR[0]), .PortOut(pOut[0]), .InstrRetired(ret[0]), .Trap(trp[0]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P2)) u2 (.clk(clk), .reset(rst[1]),
    .PortIn(pin), .ALUResultOut(aluR[1]), .PortOut(pOut[1]), .InstrRetired(ret[1]), .Trap(trp[1]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P3)) u3 (.clk(clk), .reset(rst[2]),
    .PortIn(pin), .ALUResultOut(aluR[2]), .PortOut(pOut[2]), .InstrRetired(ret[2]), .Trap(trp[2]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P4)) u4 (.clk(clk), .reset(rst[3]),
    .PortIn(pin), .ALUResultOut(aluR[3]), .PortOut(pOut[3]), .InstrRetired(ret[3]), .Trap(trp[3]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P5)) u5 (.clk(clk), .reset(rst[4]),
    .PortIn(pin), .ALUResultOut(aluR[4]), .PortOut(pOut[4]), .InstrRetired(ret[4]), .Trap(trp[4]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P6)) u6 (.clk(clk), .reset(rst[5]),
    .PortIn(pin), .ALUResultOut(aluR[5]), .PortOut(pOut[5]), .InstrRetired(ret[5]), .Trap(trp[5]));
  mips_multicycle_processor #(.MEMORY_DEPTH(16), .DATA_DEPTH(16), .PROGRAM(P7)) u7 (.clk(clk), .reset(rst[6]),
    .PortIn(pin), .ALUResultOut(aluR[6]), .PortOut(pOut[6]), .InstrRetired(ret[6]), .Trap(trp[6]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    int p [$];
    step(1);
    chk("rst_pc", u1.pc, 32'h0040_0000);
    chk("rst_sp", u1.regFile[29], 32'h1001_003C);
    chk("rst_t0", u1.regFile[8], 32'h0);
    chk("rst_alu", aluR[0], 32'h0);
    chk("rst_port", pOut[1], 32'h0);
    chk("rst_ret", 32'(ret[0]), 32'h0);
    chk("rst_trap", 32'(trp[6]), 32'h0);
    rst[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (ret[0]) p.push_back(i);
    end
    chk("addi_pulses", p.size(), 32'd2);
    chk("addi_pulse0", p[0], 32'd3);
    chk("addi_pulse1", p[1], 32'd7);
    chk("addi_t0", u1.regFile[8], 32'h0000_0005);
    chk("addi_t1", u1.regFile[9], 32'hFFFF_FFFE);
    chk("addi_alu", aluR[0], 32'hFFFF_FFFE);
    step(4);
    chk("rom_oob_pc", u1.pc, 32'h0040_000C);
    chk("rom_oob_t1", u1.regFile[9], 32'hFFFF_FFFE);
    rst[1] = 1'b1;
    step(15);
    chk("sw_mem_ret", 32'(ret[1]), 32'h1);
    chk("sw_mem_port", pOut[1], 32'h0);
    #1 rst[1] = 1'b0;
    #1;
    chk("async_rst_pc", u2.pc, 32'h0040_0000);
    chk("async_rst_ret", 32'(ret[1]), 32'h0);
    step(2);
    chk("abort_sw_port", pOut[1], 32'h0);
    rst[1] = 1'b1;
    step(15);
    chk("port_at15", pOut[1], 32'h0);
    chk("port_at", u2.regFile[1], 32'h1001_0024);
    step(1);
    chk("port_at16", pOut[1], 32'h0000_00A5);
    pin = 8'h3C;
    p.delete();
    rst[2] = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      step(1);
      if (ret[2]) p.push_back(i);
    end
    chk("mem_pulses", p.size(), 32'd7);
    chk("mem_pulse0", p[0], 32'd3);
    chk("lw_pulse", p[1], 32'd8);
    chk("portin_t2", u3.regFile[10], 32'h0000_003C);
    chk("ram_rt_t4", u3.regFile[12], 32'h0000_003C);
    chk("ram_oob_t5", u3.regFile[13], 32'h0);
    chk("mem_alu", aluR[2], 32'h1001_0040);
    p.delete();
    rst[3] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      if (ret[3]) p.push_back(i);
    end
    chk("beq_pulses", p.size(), 32'd3);
    chk("beq_pulse0", p[0], 32'd2);
    chk("beq_pulse2", p[2], 32'd8);
    chk("beq_pc", u4.pc, 32'h0040_0000);
    rst[4] = 1'b1;
    step(3);
    chk("bne_pc", u5.pc, 32'h0040_0004);
    rst[5] = 1'b1;
    step(3);
    chk("jal_ra", u6.regFile[31], 32'h0040_0004);
    chk("jal_pc", u6.pc, 32'h0040_0010);
    step(3);
    chk("jr_pc", u6.pc, 32'h0040_0004);
    rst[6] = 1'b1;
    step(1);
    chk("ill_ret", 32'(ret[6]), TRAP_ON ? 32'h0 : 32'h1);
    step(1);
    chk("ill_trap", 32'(trp[6]), 32'(TRAP_ON));
    step(4);
    chk("ill_pc", u7.pc, TRAP_ON ? 32'h0040_0004 : 32'h0040_0008);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_processor.md
# mips_multicycle_processor

Multi-cycle MIPS core that replaces the single-cycle top level. A control FSM steps each instruction through up to five states, sharing one ALU. The core adds taken branches, jumps, load/store to an internal data RAM, and memory-mapped `PortIn`/`PortOut`. Program ROM depth, data RAM depth and port widths are parameters. The core is the top of the processor hierarchy and drives the board I/O directly.

## Interface
- `MEMORY_DEPTH`, 64: program ROM depth in 32-bit words.
- `DATA_DEPTH`, 64: data RAM depth in 32-bit words.
- `PORT_IN_WIDTH`, 8: width of `PortIn`; zero-extended on read.
- `PORT_OUT_WIDTH`, 32: width of `PortOut`; takes the low bits of the stored word.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PortIn` in `PORT_IN_WIDTH`: input port, read at address 0x1001_0028.
- `ALUResultOut` out 32: registered ALU result (ALUOut register).
- `PortOut` out `PORT_OUT_WIDTH`: output port register, written at address 0x1001_0024.
- `InstrRetired` out 1: one-cycle pulse in the last state of each completed instruction.
- `Trap` out 1: sticky illegal-opcode flag (see Configuration).

## Operation
- Instruction set:
  - R-type: add, sub, and, or, nor, slt, sll, srl, jr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- ALU and address arithmetic is 32-bit wrap-around; no overflow exceptions.
- addi, slti, lw/sw offsets and branch offsets are sign-extended. andi and ori are zero-extended. lui produces `{imm,16'h0}`.
- FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
  - FETCH: IR <= ROM[PC]; PC <= PC+4.
  - DECODE: A and B <= register file reads; ALUOut <= PC + (sext(imm)<<2), the branch target.
  - EXECUTE:
    - ALU ops: ALUOut <= result.
    - beq/bne: compare A and B; if taken, PC <= ALUOut; retire.
    - j: PC <= {PC[31:28], target, 2'b00}; retire.
    - jal: same as j, plus $31 <= PC; retire.
    - jr: PC <= A; retire.
    - lw/sw: ALUOut <= address.
  - MEMORY:
    - sw: write RAM or port; retire.
    - lw: MDR <= read data.
  - WRITEBACK: rd (R-type) or rt (I-type, lw) <= ALUOut or MDR; retire.
- Cycles per instruction: ALU 4, lw 5, sw 4, branch/jump 3.
- Address map:
  - PC reset value 0x0040_0000; ROM index = (PC−0x0040_0000)>>2.
  - Data RAM at 0x1001_0000; word index = (addr−0x1001_0000)>>2.
  - The low two address bits are ignored (no misalignment fault).
- Boundaries:
  - ROM index ≥ `MEMORY_DEPTH` reads 0x0000_0000, which executes as a NOP.
  - RAM index ≥ `DATA_DEPTH`, other than the port addresses: read returns 0; write is ignored.
  - Writes to $0 are discarded; $0 always reads 0.
- Reset values:
  - PC 0x0040_0000; state FETCH.
  - All registers 0, except $29 = 0x1001_0000 + 4·`DATA_DEPTH` − 4.
  - IR, A, B, MDR, ALUOut all 0.
  - `ALUResultOut` 0, `PortOut` 0, `InstrRetired` 0, `Trap` 0.
  - Data RAM is not reset.

## Timing
- ROM and RAM reads are combinational and are captured into IR or MDR at the end of their state.
- The RAM write commits at the end of MEMORY, so a following lw sees the new data.
- The register file writes at the end of WRITEBACK or EXECUTE (jal). Reads in the next instruction's DECODE see the new value.
- `PortOut` updates on the edge that ends sw's MEMORY state.
- `PortIn` is sampled on the edge that ends lw's MEMORY state. It is not synchronised; the source must already be synchronous to `clk`.
- `InstrRetired` is high for exactly one cycle per instruction, during the final state.
- Reset asserted in any state takes effect immediately, without waiting for a clock edge:
  - the in-flight instruction is abandoned;
  - a pending sw does not write;
  - after release, the first FETCH occurs on the first rising edge.

## Configuration
- `MIPS_TRAP_EN` defined:
  - an unsupported opcode, or funct value under opcode 0, moves DECODE → TRAP;
  - TRAP is terminal until reset; `Trap`=1 and the PC freezes;
  - `InstrRetired` is not pulsed for the trapping instruction.
- `MIPS_TRAP_EN` undefined:
  - an unsupported instruction retires as a NOP after DECODE (2 cycles, with `InstrRetired` pulsed);
  - `Trap` is tied to 0.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - the FSM state enum;
  - ALU operation codes;
  - address constants: TEXT_BASE, DATA_BASE, PORT_OUT_ADDR, PORT_IN_ADDR.
- Sub-module `mips_control_fsm`: owns the state register and decodes opcode/funct into datapath enables and mux selects. The datapath, register file and memories stay in the top level.

## Test plan
- Reset release with ROM = `addi $t0,$0,5; addi $t1,$t0,-7` → after 8 cycles, $t1 = 0xFFFF_FFFE and `ALUResultOut` = 0xFFFF_FFFE; two `InstrRetired` pulses, 4 cycles apart.
- `lui $at,0x1001; ori $at,$at,0x24; addi $t0,$0,0xA5; sw $t0,0($at)` → `PortOut` = 0xA5 exactly 16 cycles after reset release.
- `PortIn` = 0x3C, then `lw $t2,0x28` from 0x1001_0000 → $t2 = 0x0000_003C; the lw takes 5 cycles.
- `beq $0,$0,-1` (offset 0xFFFF) → PC stays at 0x0040_0000 and `InstrRetired` pulses every 3 cycles. With bne in its place, PC advances to 0x0040_0004.
- `jal` to 0x0040_0010, then `jr $ra` there → $31 = 0x0040_0004 and execution resumes at 0x0040_0004.
- Opcode 0x3F: with `MIPS_TRAP_EN`, `Trap` = 1 two cycles after fetch and the PC freezes. Without it, execution continues. Asserting reset in the MEMORY state of a sw leaves `PortOut` = 0.
